// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone initiator: host request -> pipelined strobe -> ack/timeout -> one-cycle response.
// Optional: define WB_INITIATOR_POSTED_WRITE_EN to complete writes on strobe acceptance without awaiting ack.
//
// state | meaning
// IDLE  | ready for a host request
// REQ   | strobe asserted, waiting for the responder to take it (stall low)
// WAIT  | strobe taken, waiting for ack or timeout
// RESP  | one-cycle completion pulse to the host
module wb_initiator #(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              wb_clk_i,
   input  logic              wb_reset_n_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_data_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              rsp_error_o,
   output logic              wb_strobe_o,
   output logic              wb_write_o,
   output logic [ADDR_W-1:0] wb_addr_o,
   output logic [DATA_W-1:0] wb_data_o,
   input  logic [DATA_W-1:0] wb_data_i,
   input  logic              wb_ack_i,
   input  logic              wb_stall_i
);

`ifdef WB_INITIATOR_POSTED_WRITE_EN
   localparam bit POSTED_C = 1'b1;
`else
   localparam bit POSTED_C = 1'b0;
`endif

   localparam logic [7:0] TMO_C = 8'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t            r_state, w_state_nxt;
   logic [7:0]        r_cnt, w_cnt_nxt, w_cnt_inc;
   logic              r_ready, w_ready_nxt;
   logic              r_rsp_valid, w_rsp_valid_nxt;
   logic [DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
   logic              r_rsp_err, w_rsp_err_nxt;
   logic              r_stb, w_stb_nxt;
   logic              r_we, w_we_nxt;
   logic [ADDR_W-1:0] r_addr, w_addr_nxt;
   logic [DATA_W-1:0] r_data, w_data_nxt;
   logic              r_discard, w_discard_nxt;
   logic              w_ack_eff, w_tmo;

   assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
   assign w_tmo     = (w_cnt_inc >= TMO_C);
   // The late ack belonging to a posted write must not complete the next transfer.
   assign w_ack_eff = wb_ack_i && !r_discard;

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_stb_nxt      = 1'b0;
      w_rsp_data_nxt = '0;
      w_rsp_err_nxt  = 1'b0;
      w_we_nxt       = r_we;
      w_addr_nxt     = r_addr;
      w_data_nxt     = r_data;
      w_discard_nxt  = r_discard;
      case (r_state)
         S_IDLE: begin
            if (wb_ack_i) w_discard_nxt = 1'b0;
            if (req_valid_i && r_ready) begin
               w_we_nxt    = req_write_i;
               w_addr_nxt  = req_addr_i;
               w_data_nxt  = req_data_i;
               w_cnt_nxt   = '0;
               w_stb_nxt   = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            w_cnt_nxt = w_cnt_inc;
            if (!wb_stall_i) begin
               w_discard_nxt = 1'b0;
               if (POSTED_C && r_we) begin
                  w_discard_nxt = !w_ack_eff;
                  w_state_nxt   = S_RESP;
               end else if (w_ack_eff) begin
                  w_rsp_data_nxt = r_we ? '0 : wb_data_i;
                  w_state_nxt    = S_RESP;
               end else if (w_tmo) begin
                  w_rsp_err_nxt = 1'b1;
                  w_state_nxt   = S_RESP;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end else begin
               if (wb_ack_i) w_discard_nxt = 1'b0;
               if (w_tmo) begin
                  w_rsp_err_nxt = 1'b1;
                  w_state_nxt   = S_RESP;
               end else begin
                  w_stb_nxt = 1'b1;
               end
            end
         end
         S_WAIT: begin
            w_cnt_nxt = w_cnt_inc;
            if (wb_ack_i) begin
               w_rsp_data_nxt = r_we ? '0 : wb_data_i;
               w_state_nxt    = S_RESP;
            end else if (w_tmo) begin
               w_rsp_err_nxt = 1'b1;
               w_state_nxt   = S_RESP;
            end
         end
         S_RESP: begin
            if (wb_ack_i) w_discard_nxt = 1'b0;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_rsp_valid_nxt = (w_state_nxt == S_RESP);
      w_ready_nxt     = (w_state_nxt == S_IDLE);
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_reset_n_i) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_ready     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
         r_stb       <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_data      <= '0;
         r_discard   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_ready     <= w_ready_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_data  <= w_rsp_data_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_stb       <= w_stb_nxt;
         r_we        <= w_we_nxt;
         r_addr      <= w_addr_nxt;
         r_data      <= w_data_nxt;
         r_discard   <= POSTED_C && w_discard_nxt;
      end
   end

   assign req_ready_o = r_ready;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_data_o  = r_rsp_data;
   assign rsp_error_o = r_rsp_err;
   assign wb_strobe_o = r_stb;
   assign wb_write_o  = r_we;
   assign wb_addr_o   = r_addr;
   assign wb_data_o   = r_data;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator; expected values are hand-derived cycle by cycle.
module tb_wb_initiator;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid, req_ready, req_write;
   logic [4:0] req_addr;
   logic [7:0] req_data;
   logic       rsp_valid, rsp_error;
   logic [7:0] rsp_data;
   logic       stb, we;
   logic [4:0] addr;
   logic [7:0] dout, din;
   logic       ack, stall;

   int checks = 0;
   int errors = 0;

   wb_initiator #(.ADDR_W(5), .DATA_W(8), .TIMEOUT(15)) dut (
      .wb_clk_i(clk), .wb_reset_n_i(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_data_i(req_data),
      .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_error_o(rsp_error),
      .wb_strobe_o(stb), .wb_write_o(we), .wb_addr_o(addr), .wb_data_o(dout),
      .wb_data_i(din), .wb_ack_i(ack), .wb_stall_i(stall)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive a request while idle; returns after the accepting edge (cycle N+1).
   task automatic issue(input logic w, input logic [4:0] a, input logic [7:0] d);
      req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
      step();
      req_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
      din = '0; ack = 1'b0; stall = 1'b0;
      step(); step();
      chk("rst_ready", req_ready, 0);
      chk("rst_stb", stb, 0);
      chk("rst_rsp", rsp_valid, 0);
      rst_n = 1'b1;
      step();
      chk("idle_ready", req_ready, 1);

      // read, no stall, registered ack
      issue(1'b0, 5'h03, 8'h00);
      chk("t1_stb", stb, 1);
      chk("t1_addr", addr, 5'h03);
      chk("t1_we", we, 0);
      chk("t1_ready", req_ready, 0);
      step();
      chk("t1_stb_drop", stb, 0);
      ack = 1'b1; din = 8'hA5;
      step();
      ack = 1'b0;
      chk("t1_rsp", rsp_valid, 1);
      chk("t1_data", rsp_data, 8'hA5);
      chk("t1_err", rsp_error, 0);
      step();
      chk("t1_rsp_one", rsp_valid, 0);
      chk("t1_ready_back", req_ready, 1);

      // write with three stall cycles
      issue(1'b1, 5'h01, 8'h3C);
      for (int i = 0; i < 4; i++) begin
         chk("t2_stb", stb, 1);
         chk("t2_addr", addr, 5'h01);
         chk("t2_data", dout, 8'h3C);
         chk("t2_we", we, 1);
         stall = (i < 3);
         step();
      end
      chk("t2_stb_drop", stb, 0);
`ifdef WB_INITIATOR_POSTED_WRITE_EN
      chk("t2p_rsp", rsp_valid, 1);
      chk("t2p_err", rsp_error, 0);
      chk("t2p_data", rsp_data, 0);
      step();
`else
      chk("t2_no_rsp", rsp_valid, 0);
      ack = 1'b1; din = 8'hFF;
      step();
      ack = 1'b0;
      chk("t2_rsp", rsp_valid, 1);
      chk("t2_data", rsp_data, 0);
      chk("t2_err", rsp_error, 0);
      step();
`endif

      // read, never acked: error 15 cycles after strobe
      issue(1'b0, 5'h0A, 8'h00);
      chk("t3_stb", stb, 1);
      for (int i = 0; i < 14; i++) begin
         step();
         chk("t3_wait_rsp", rsp_valid, 0);
         chk("t3_wait_stb", stb, 0);
      end
      step();
      chk("t3_rsp", rsp_valid, 1);
      chk("t3_err", rsp_error, 1);
      chk("t3_data", rsp_data, 0);
      chk("t3_stb", stb, 0);
      step();
      chk("t3_ready", req_ready, 1);

      // ack in the strobe cycle, then back-to-back request
      issue(1'b0, 5'h04, 8'h00);
      ack = 1'b1; din = 8'h5A;
      step();
      ack = 1'b0;
      chk("t4_rsp", rsp_valid, 1);
      chk("t4_data", rsp_data, 8'h5A);
      chk("t4_ready_resp", req_ready, 0);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h07;
      step();
      chk("t4_ignored", stb, 0);
      chk("t4_ready", req_ready, 1);
      chk("t4_rsp_one", rsp_valid, 0);
      step();
      req_valid = 1'b0;
      chk("t4_stb2", stb, 1);
      chk("t4_addr2", addr, 5'h07);
      ack = 1'b1; din = 8'h11;
      step();
      ack = 1'b0;
      chk("t4_rsp2", rsp_valid, 1);
      chk("t4_data2", rsp_data, 8'h11);
      step();

      // reset while in WAIT
      issue(1'b0, 5'h09, 8'h00);
      step();
      chk("t5_wait_stb", stb, 0);
      rst_n = 1'b0;
      step();
      chk("t5_ready", req_ready, 0);
      chk("t5_stb", stb, 0);
      chk("t5_addr", addr, 0);
      chk("t5_rsp", rsp_valid, 0);
      rst_n = 1'b1;
      step();
      chk("t5_ready_rel", req_ready, 1);
      ack = 1'b1; din = 8'hEE;
      step();
      ack = 1'b0;
      chk("t5_late_ack", rsp_valid, 0);
      chk("t5_late_stb", stb, 0);
      chk("t5_late_ready", req_ready, 1);
      step();
      chk("t5_late_ack2", rsp_valid, 0);

`ifdef WB_INITIATOR_POSTED_WRITE_EN
      // posted write, then a read that must ignore the stray ack
      issue(1'b1, 5'h02, 8'h77);
      step();
      chk("t6_rsp", rsp_valid, 1);
      chk("t6_err", rsp_error, 0);
      step();
      chk("t6_ready", req_ready, 1);
      ack = 1'b1; din = 8'h99;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h02;
      step();
      req_valid = 1'b0; ack = 1'b0;
      chk("t6_rd_stb", stb, 1);
      step();
      chk("t6_rd_wait", rsp_valid, 0);
      ack = 1'b1; din = 8'hC3;
      step();
      ack = 1'b0;
      chk("t6_rd_rsp", rsp_valid, 1);
      chk("t6_rd_data", rsp_data, 8'hC3);
      step();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Wishbone bus initiator: turns single-transfer requests from a host-side agent (CPU bus bridge, register loader) into pipelined Wishbone strobes toward responders such as the video controller register file.
- Handles stall, waits for ack, returns read data, and aborts with an error on a missing ack.
- One transaction in flight at a time. Sits between the CPU-side bus logic and the Wishbone fabric.

Parameters:
- ADDR_W, 5, Wishbone address width.
- DATA_W, 8, Wishbone data width.
- TIMEOUT, 15, maximum cycles from first strobe to ack before abort; legal range 2..255.

Ports:
- wb_clk_i  in  1  bus clock; all logic on rising edge.
- wb_reset_n_i  in  1  synchronous reset, active-low.
- req_valid_i  in  1  host request valid.
- req_ready_o  out  1  initiator accepts request this cycle.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_W  request address.
- req_data_i  in  DATA_W  write data.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_data_o  out  DATA_W  read data; valid with rsp_valid_o.
- rsp_error_o  out  1  timeout abort flag; valid with rsp_valid_o.
- wb_strobe_o  out  1  transaction valid.
- wb_write_o  out  1  write enable.
- wb_addr_o  out  ADDR_W  address.
- wb_data_o  out  DATA_W  write data.
- wb_data_i  in  DATA_W  read data; sampled on ack.
- wb_ack_i  in  1  responder ack.
- wb_stall_i  in  1  responder stall.

Behaviour:
- Reset (wb_reset_n_i=0 at clock edge) drives all outputs to 0 and sets state IDLE; timeout counter = 0. Reset mid-transaction drops strobe immediately and produces no response.
- All outputs are registered.
- State IDLE:
  - req_ready_o=1.
  - On req_valid_i=1, latch write, addr and data into the wb_*_o registers, set wb_strobe_o=1 next cycle, clear the counter, go to REQ.
- State REQ:
  - wb_strobe_o=1; address, data and write are held stable.
  - If wb_stall_i=0, the strobe is accepted this cycle: deassert strobe next cycle.
  - If wb_ack_i is also 1 that cycle, go to RESP; otherwise go to WAIT.
  - If wb_stall_i=1, stay in REQ.
- State WAIT:
  - wb_strobe_o=0.
  - On wb_ack_i=1, capture wb_data_i (reads only; rsp_data_o=0 for writes) and go to RESP.
- Timeout (REQ and WAIT):
  - The counter increments each cycle spent in REQ or WAIT.
  - When the counter reaches TIMEOUT with no ack, go to RESP with rsp_error_o=1 and rsp_data_o=0.
  - Strobe drops on that transition.
- Ack wins ties: an ack in the same cycle the counter hits TIMEOUT completes normally with rsp_error_o=0.
- State RESP:
  - rsp_valid_o=1 for exactly one cycle, then IDLE.
  - req_ready_o=0 in REQ, WAIT and RESP; the earliest next acceptance is the cycle after RESP.
- Latency with no stall and a responder that registers its ack (ack one cycle after strobe):
  - Request accepted at cycle N.
  - Strobe high at N+1.
  - Ack at N+2.
  - rsp_valid_o at N+3.
- Ignored inputs:
  - A spurious wb_ack_i in IDLE or RESP is ignored.
  - req_* inputs are ignored when req_ready_o=0.
- Width rules: the counter is 8 bits, saturating.

Optional Feature:
- Macro WB_INITIATOR_POSTED_WRITE_EN.
- When defined:
  - A write completes as soon as its strobe is accepted (stall=0): REQ goes directly to RESP, rsp_valid_o is pulsed and rsp_error_o=0.
  - The ack for a posted write is not awaited; the next transaction's timeout window is unaffected.
  - One stray ack arriving in IDLE or REQ immediately after a posted write is discarded.
  - Reads are unchanged.
- When undefined: writes wait for ack exactly as reads do.

Test Plan:
- Read, no stall, responder acks 1 cycle after strobe, addr=5'h03, wb_data_i=8'hA5 -> strobe high 1 cycle, rsp_valid_o at N+3, rsp_data_o=8'hA5, rsp_error_o=0.
- Write addr=5'h01, data=8'h3C, wb_stall_i high for 3 cycles -> strobe held 4 cycles with stable addr and data; after ack, rsp_valid_o=1 and rsp_data_o=0.
- Read with no ack ever, TIMEOUT=15 -> rsp_valid_o with rsp_error_o=1 exactly 15 cycles after strobe asserts; strobe dropped.
- Ack coincident with stall=0 in the strobe cycle -> goes directly to RESP, rsp_valid_o the next cycle; a second back-to-back request is accepted the cycle after RESP.
- Reset asserted while in WAIT -> next cycle all outputs 0 and req_ready_o=0; after release req_ready_o=1, no rsp_valid_o, and a late ack is ignored.
- With WB_INITIATOR_POSTED_WRITE_EN: write accepted with no stall -> rsp_valid_o the cycle after strobe acceptance, before the ack; the following read completes with correct data despite the stray ack.
